// File: rtl/stack_controller_pkg.sv
// Shared constants for the stack controller slice.
// Frame field widths, frame width and FSM state encodings.
package stack_controller_pkg;

  localparam int N_W     = 8;
  localparam int FLAG_W  = 8;
  localparam int RES_W   = 8;
  localparam int FRAME_W = N_W + FLAG_W + RES_W;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t WRITE   = 3'd1;
  localparam state_t READ    = 3'd2;
  localparam state_t WAIT_RD = 3'd3;
  localparam state_t DONE    = 3'd4;

endpackage

// File: rtl/stack_controller_ram.sv
// stack_ram: DEPTH x WIDTH single-port synchronous RAM.
// Ports: clk, we, addr, wdata; rdata is registered (1-cycle latency).
module stack_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/stack_controller.sv
// Stack controller: push/pop FSM, stack pointer, flags.
// Ports: clk, rst_n, pushSig/popSig/push_data in; pop_data, readySig, empty, full, count, err out.
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = FRAME_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pushSig,
  input  logic                       popSig,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       readySig,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] DMAX = CW'(DEPTH);

  state_t           state;
  logic [CW-1:0]    sp;
  logic [CW-1:0]    spm1;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rdata;
  logic             rd_ok;
  logic             we;
  logic [AW-1:0]    addr;

  assign empty    = (sp == '0);
  assign full     = (sp == DMAX);
  assign count    = sp;
  assign readySig = (state == DONE);

  assign spm1 = sp - ONE;
  assign we   = (state == WRITE) && !full;
  assign addr = (state == WRITE) ? sp[AW-1:0]
                                 : spm1[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sp       <= '0;
      data_q   <= '0;
      pop_data <= '0;
      err      <= 1'b0;
      rd_ok    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pushSig) begin
            state  <= WRITE;
            data_q <= push_data;
          end else if (popSig) begin
            state <= READ;
          end
        end
        WRITE: begin
          if (!full)
            sp <= sp + ONE;
          else
            err <= 1'b1;
          state <= DONE;
        end
        READ: begin
          // Empty pops still walk WAIT_RD so timing stays uniform
          if (!empty) begin
            sp    <= spm1;
            rd_ok <= 1'b1;
          end else begin
            err   <= 1'b1;
            rd_ok <= 1'b0;
          end
          state <= WAIT_RD;
        end
        WAIT_RD: begin
          if (rd_ok)
            pop_data <= rdata;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (data_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_stack_controller.sv
// Directed self-checking bench for stack_controller.
// Drives push/pop handshakes and checks data, flags and latency.
module tb_stack_controller;

  logic        clk;
  logic        rst_n;
  logic        pushSig;
  logic        popSig;
  logic [23:0] push_data;
  logic [23:0] pop_data;
  logic        readySig;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  stack_controller #(.DEPTH(16), .WIDTH(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushSig   (pushSig),
    .popSig    (popSig),
    .push_data (push_data),
    .pop_data  (pop_data),
    .readySig  (readySig),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure cycles from the request cycle to
  // readySig, drop the request on the edge that samples readySig.
  task automatic op(input logic ps, input logic pp,
                    input logic [23:0] d, input int exp_lat,
                    input string tag);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    pushSig = ps;
    popSig = pp;
    push_data = d;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 2) push_data = ~d;
      if (readySig) lat = i - 1;
    end
    chk({tag, " latency"}, lat, exp_lat);
    @(posedge clk); #1;
    pushSig = 1'b0;
    popSig = 1'b0;
    @(negedge clk);
    chk({tag, " pulse width"}, {31'd0, readySig}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pushSig = 1'b0;
    popSig = 1'b0;
    push_data = 24'h0;
    #3;
    chk("rst empty", {31'd0, empty}, 32'd1);
    chk("rst full", {31'd0, full}, 32'd0);
    chk("rst count", {27'd0, count}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst ready", {31'd0, readySig}, 32'd0);
    chk("rst pop_data", {8'd0, pop_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(1, 0, 24'h050101, 2, "push1");
    chk("push1 count", {27'd0, count}, 32'd1);
    chk("push1 empty", {31'd0, empty}, 32'd0);
    chk("push1 err", {31'd0, err}, 32'd0);
    op(0, 1, 24'h0, 3, "pop1");
    chk("pop1 data", {8'd0, pop_data}, 32'h050101);
    chk("pop1 empty", {31'd0, empty}, 32'd1);

    op(1, 0, 24'h0A0000, 2, "pushA");
    op(1, 0, 24'h0B0000, 2, "pushB");
    op(1, 0, 24'h0C0000, 2, "pushC");
    chk("abc count", {27'd0, count}, 32'd3);
    op(0, 1, 24'h0, 3, "popC");
    chk("popC data", {8'd0, pop_data}, 32'h0C0000);
    op(0, 1, 24'h0, 3, "popB");
    chk("popB data", {8'd0, pop_data}, 32'h0B0000);
    op(0, 1, 24'h0, 3, "popA");
    chk("popA data", {8'd0, pop_data}, 32'h0A0000);
    chk("abc empty", {31'd0, empty}, 32'd1);
    chk("abc err", {31'd0, err}, 32'd0);

    do_reset();
    op(0, 1, 24'h0, 3, "pop empty");
    chk("pop empty err", {31'd0, err}, 32'd1);
    chk("pop empty count", {27'd0, count}, 32'd0);
    chk("pop empty data", {8'd0, pop_data}, 32'd0);

    do_reset();
    chk("reset clears err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 16; i++)
      op(1, 0, 24'h100000 + 24'(i), 2, "fill");
    chk("fill count", {27'd0, count}, 32'd16);
    chk("fill full", {31'd0, full}, 32'd1);
    chk("fill err", {31'd0, err}, 32'd0);
    op(1, 0, 24'hEEEEEE, 2, "push full");
    chk("push full err", {31'd0, err}, 32'd1);
    chk("push full count", {27'd0, count}, 32'd16);
    chk("push full full", {31'd0, full}, 32'd1);
    for (int i = 15; i >= 0; i--) begin
      op(0, 1, 24'h0, 3, "drain");
      chk("drain data", {8'd0, pop_data}, 32'h100000 + 32'(i));
    end
    chk("drain empty", {31'd0, empty}, 32'd1);

    do_reset();
    op(1, 0, 24'h000011, 2, "pre1");
    op(1, 0, 24'h000022, 2, "pre2");
    op(1, 1, 24'h000077, 2, "both");
    chk("both count", {27'd0, count}, 32'd3);
    chk("both err", {31'd0, err}, 32'd0);
    op(0, 1, 24'h0, 3, "pop both");
    chk("pop both data", {8'd0, pop_data}, 32'h000077);

    // Abort a pop while it sits in WAIT_RD
    @(posedge clk); #1;
    popSig = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    popSig = 1'b0;
    #1;
    chk("abort ready", {31'd0, readySig}, 32'd0);
    chk("abort count", {27'd0, count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort no pulse", {31'd0, readySig}, 32'd0);
    end
    op(1, 0, 24'h123456, 2, "post abort push");
    chk("post abort count", {27'd0, count}, 32'd1);
    op(0, 1, 24'h0, 3, "post abort pop");
    chk("post abort data", {8'd0, pop_data}, 32'h123456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
